// File: rtl/telemetry_rx.sv
// telemetry_rx: 8N1 UART receiver plus telemetry frame parser.
// Frame: AA 55 BH BL CH CL TH TL. The high-nibble bytes must carry zero in [7:4].
// Outputs are loaded together only when a whole good frame has arrived.
// Optional inter-byte timeout: define TELEM_RX_TIMEOUT_EN.
module telemetry_rx #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_rdy,
  output logic        pkt_err
);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] P_HDR1 = 3'd0;
  localparam logic [2:0] P_HDR2 = 3'd1;
  localparam logic [2:0] P_BH   = 3'd2;
  localparam logic [2:0] P_BL   = 3'd3;
  localparam logic [2:0] P_CH   = 3'd4;
  localparam logic [2:0] P_CL   = 3'd5;
  localparam logic [2:0] P_TH   = 3'd6;
  localparam logic [2:0] P_TL   = 3'd7;

  // Counter reload values: expiry happens when the counter reaches zero,
  // so loading N-1 gives an interval of N clocks.
  localparam logic [11:0] HALF_LOAD = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] FULL_LOAD = 12'(BAUD_DIV - 1);

  logic        rx_meta, rx_sync, rx_prev;
  logic        fall_edge;
  logic [1:0]  rx_state;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        byte_done;
  logic        frame_err;
  logic [2:0]  p_state;
  logic [3:0]  sh_b_hi, sh_c_hi, sh_t_hi;
  logic [7:0]  sh_b_lo, sh_c_lo;
  logic        tmo_fire;

  assign fall_edge = rx_prev & ~rx_sync;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit receiver: mid-bit sampling, returns to idle right at the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (fall_edge) begin
            rx_state <= RX_START;
            baud_cnt <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (baud_cnt == 12'd0) begin
            if (rx_sync) begin
              // Line went back high before mid start bit: glitch, ignore.
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              baud_cnt <= FULL_LOAD;
              bit_cnt  <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == 12'd0) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            baud_cnt  <= FULL_LOAD;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
            else                 bit_cnt  <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        default: begin
          if (baud_cnt == 12'd0) begin
            rx_state <= RX_IDLE;
            if (rx_sync) byte_done <= 1'b1;
            else         frame_err <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
      endcase
    end
  end

`ifdef TELEM_RX_TIMEOUT_EN
  localparam int TMO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_run;

  assign tmo_run  = (p_state != P_HDR1) && (rx_state == RX_IDLE) && !fall_edge;
  assign tmo_fire = tmo_run && (tmo_cnt == TMO_W'(TMO_LIMIT - 1));

  // Inter-byte idle counter; cleared by start detection or an idle parser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  tmo_cnt <= '0;
    else if (tmo_run && !tmo_fire) tmo_cnt <= tmo_cnt + 1'b1;
    else                         tmo_cnt <= '0;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Frame parser: shadows hold the partial frame, outputs load only on TL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state    <= P_HDR1;
      sh_b_hi    <= '0;
      sh_b_lo    <= '0;
      sh_c_hi    <= '0;
      sh_c_lo    <= '0;
      sh_t_hi    <= '0;
      batt_v     <= '0;
      avg_curr   <= '0;
      avg_torque <= '0;
      pkt_rdy    <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      pkt_rdy <= 1'b0;
      pkt_err <= 1'b0;
      if (frame_err) begin
        p_state <= P_HDR1;
        pkt_err <= 1'b1;
      end else if (byte_done) begin
        case (p_state)
          P_HDR1: if (shift_reg == 8'hAA) p_state <= P_HDR2;
          P_HDR2: begin
            if (shift_reg == 8'h55)      p_state <= P_BH;
            else if (shift_reg != 8'hAA) p_state <= P_HDR1;
          end
          P_BH, P_CH, P_TH: begin
            if (shift_reg[7:4] != 4'h0) begin
              p_state <= P_HDR1;
              pkt_err <= 1'b1;
            end else begin
              if (p_state == P_BH) sh_b_hi <= shift_reg[3:0];
              if (p_state == P_CH) sh_c_hi <= shift_reg[3:0];
              if (p_state == P_TH) sh_t_hi <= shift_reg[3:0];
              p_state <= p_state + 3'd1;
            end
          end
          P_BL: begin
            sh_b_lo <= shift_reg;
            p_state <= P_CH;
          end
          P_CL: begin
            sh_c_lo <= shift_reg;
            p_state <= P_TH;
          end
          default: begin
            batt_v     <= {sh_b_hi, sh_b_lo};
            avg_curr   <= {sh_c_hi, sh_c_lo};
            avg_torque <= {sh_t_hi, shift_reg};
            pkt_rdy    <= 1'b1;
            p_state    <= P_HDR1;
          end
        endcase
      end else if (tmo_fire) begin
        p_state <= P_HDR1;
        pkt_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_telemetry_rx.sv
// tb_telemetry_rx: directed and randomized frames against a byte-level protocol model.
module tb_telemetry_rx;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_rdy, pkt_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_rdy_cyc = 0;
  int byte_start_cyc = 0;

  // Reference model state: expected pulse counts and output words.
  int          exp_rdy = 0;
  int          exp_err = 0;
  logic [11:0] exp_b = '0;
  logic [11:0] exp_c = '0;
  logic [11:0] exp_t = '0;
  int          pos = 0;
  logic [7:0]  frm [8];

  telemetry_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX),
    .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
    .pkt_rdy(pkt_rdy), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pkt_rdy) begin
      rdy_cnt      <= rdy_cnt + 1;
      last_rdy_cyc <= cyc;
    end
    if (pkt_err) err_cnt <= err_cnt + 1;
    if (pkt_rdy && pkt_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rdy_count"}, rdy_cnt, exp_rdy);
    check({tag, "_err_count"}, err_cnt, exp_err);
    check({tag, "_batt_v"}, batt_v, exp_b);
    check({tag, "_avg_curr"}, avg_curr, exp_c);
    check({tag, "_avg_torque"}, avg_torque, exp_t);
  endtask

  // Protocol model: pos counts how many bytes of a frame have been matched.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      pos = 0;
      return;
    end
    if (pos == 0) pos = (b == 8'hAA) ? 1 : 0;
    else if (pos == 1) pos = (b == 8'h55) ? 2 : ((b == 8'hAA) ? 1 : 0);
    else if ((pos % 2 == 0) && (b > 8'h0F)) begin
      exp_err++;
      pos = 0;
    end else begin
      frm[pos] = b;
      if (pos == 7) begin
        exp_b = 12'(frm[2] * 256 + frm[3]);
        exp_c = 12'(frm[4] * 256 + frm[5]);
        exp_t = 12'(frm[6] * 256 + b);
        exp_rdy++;
        pos = 0;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic send_bit(input logic v);
    RX = v;
    repeat (BD) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    repeat (n * BD) @(negedge clk);
  endtask

  // Line pause; a long pause inside a frame is a timeout when that feature exists.
  task automatic pause(input int n);
    idle_bits(n);
`ifdef TELEM_RX_TIMEOUT_EN
    if (pos != 0 && n >= 20) begin
      exp_err++;
      pos = 0;
    end
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    byte_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    RX = 1'b1;
    if (!stop_ok) idle_bits(1);
    model_byte(b, stop_ok);
    $display("byte %02h stop_ok=%0d rdy=%0d err=%0d out=%03h/%03h/%03h",
             b, stop_ok, rdy_cnt, err_cnt, batt_v, avg_curr, avg_torque);
    check_state("byte");
  endtask

  task automatic send_frame(input logic [11:0] b, input logic [11:0] c,
                            input logic [11:0] t, input logic [3:0] bad_hi);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte({bad_hi, b[11:8]}, 1'b1);
    send_byte(b[7:0], 1'b1);
    send_byte({4'h0, c[11:8]}, 1'b1);
    send_byte(c[7:0], 1'b1);
    send_byte({4'h0, t[11:8]}, 1'b1);
    send_byte(t[7:0], 1'b1);
  endtask

  int          lat;
  int          ng;
  logic [3:0]  bad;
  logic [11:0] rb, rc, rt;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_batt_v", batt_v, 12'h000);
    check("reset_avg_curr", avg_curr, 12'h000);
    check("reset_avg_torque", avg_torque, 12'h000);
    check("reset_pkt_rdy", pkt_rdy, 1'b0);
    check("reset_pkt_err", pkt_err, 1'b0);
    rst_n = 1'b1;
    idle_bits(2);

    // Basic frame and pulse latency from the TL start edge
    send_frame(12'hA98, 12'h123, 12'h456, 4'h0);
    lat = last_rdy_cyc - byte_start_cyc;
    check("rdy_latency_in_window", (lat >= BD * 19 / 2 && lat <= BD * 19 / 2 + 8), 1'b1);
    idle_bits(2);

    // Garbage then sync
    send_byte(8'h13, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h30, 1'b1);
    idle_bits(1);

    // Framing error on byte 5, then a good frame
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h01, 1'b0);
    send_frame(12'h321, 12'h654, 12'h987, 4'h0);

    // Bad high nibble in byte 3
    send_frame(12'hA55, 12'h111, 12'h222, 4'h1);
    idle_bits(1);

    // Short glitch: no byte, no error
    RX = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(2);
    check_state("glitch");
    send_frame(12'h0F0, 12'hF0F, 12'h5A5, 4'h0);

    // Two frames back to back with no idle
    send_frame(12'h111, 12'h222, 12'h333, 4'h0);
    send_frame(12'h444, 12'h555, 12'h666, 4'h0);
    idle_bits(1);

    // Framing error on the TL byte
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h99, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h88, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h77, 1'b0);

    // Stall after byte 4 for 25 bit times, then finish the frame
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h0B, 1'b1);
    send_byte(8'h22, 1'b1);
    pause(25);
    check_state("stall");
    send_byte(8'h03, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h44, 1'b1);
    idle_bits(1);
    send_frame(12'hCAB, 12'h0DE, 12'h7F1, 4'h0);

    // Reset in the middle of a byte
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_b = '0;
    exp_c = '0;
    exp_t = '0;
    pos = 0;
    idle_bits(2);
    check_state("midreset");
    send_frame(12'h135, 12'h246, 12'h9AC, 4'h0);

    // Randomized frames with garbage, gaps and occasional bad nibbles
    for (int f = 0; f < 6; f++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) send_byte(8'($urandom), 1'b1);
      rb  = 12'($urandom);
      rc  = 12'($urandom);
      rt  = 12'($urandom);
      bad = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      send_frame(rb, rc, rt, bad);
      pause($urandom_range(0, 3));
    end

    check("never_rdy_and_err_together", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
